// File: rtl/hazard_control.sv
// Load-use hazard detection and stall/flush control for the ID stage of a
// 5-stage pipeline; tracks its own EX/MEM history to find in-flight loads.
module hazard_control #(
  parameter int LOAD_USE_DIST = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_usesRt,
  input  logic             id_memRead,
  input  logic             id_regWrite,
  input  logic [4:0]       id_dest,
  input  logic             branch_taken,
  output logic             selector,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             exmemFlush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } decision_t;

  decision_t  decision;
  decision_t  state_reg;

  logic       ex_memRead;
  logic       ex_regWrite;
  logic [4:0] ex_dest;
  logic       mem_memRead;
  logic [4:0] mem_dest;

  logic       ex_match;
  logic       mem_match;
  logic       hazard;

  assign ex_match  = (ex_dest != 5'd0) &&
                     ((ex_dest == id_rs) || (id_usesRt && (ex_dest == id_rt)));
  assign mem_match = (mem_dest != 5'd0) &&
                     ((mem_dest == id_rs) || (id_usesRt && (mem_dest == id_rt)));

  // A load that writes no register cannot feed a dependent instruction.
  assign hazard = id_valid &&
                  ((ex_memRead && ex_regWrite && ex_match) ||
                   ((LOAD_USE_DIST == 2) && mem_memRead && mem_match));

  assign state = state_reg;

  always_comb begin
    decision   = RUN;
    selector   = 1'b1;
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    exmemFlush = 1'b0;
    if (branch_taken) begin
      decision   = FLUSH;
      selector   = 1'b0;
      ifidFlush  = 1'b1;
      exmemFlush = 1'b1;
    end else if (hazard) begin
      decision  = STALL;
      selector  = 1'b0;
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_memRead  <= 1'b0;
      ex_regWrite <= 1'b0;
      ex_dest     <= 5'd0;
      mem_memRead <= 1'b0;
      mem_dest    <= 5'd0;
      state_reg   <= RUN;
      stallCount  <= '0;
      flushCount  <= '0;
    end else begin
      // Only an instruction actually admitted into EX becomes history.
      if ((decision == RUN) && id_valid) begin
        ex_memRead  <= id_memRead;
        ex_regWrite <= id_regWrite;
        ex_dest     <= id_dest;
      end else begin
        ex_memRead  <= 1'b0;
        ex_regWrite <= 1'b0;
        ex_dest     <= 5'd0;
      end

      if (decision == FLUSH) begin
        mem_memRead <= 1'b0;
        mem_dest    <= 5'd0;
      end else begin
        mem_memRead <= ex_memRead;
        mem_dest    <= ex_dest;
      end

      state_reg <= decision;
      if (decision == STALL) stallCount <= stallCount + CNT_W'(1);
      if (decision == FLUSH) flushCount <= flushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Directed scoreboard bench for hazard_control: one instance with full
// forwarding and 32-bit counters, one with MEM-distance loads and 2-bit counters.
module tb_hazard_control;

  localparam logic [4:0] C_RUN   = 5'b11100;
  localparam logic [4:0] C_STALL = 5'b00000;
  localparam logic [4:0] C_FLUSH = 5'b01111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_usesRt = 1'b0;
  logic       id_memRead = 1'b0;
  logic       id_regWrite = 1'b0;
  logic [4:0] id_dest = '0;
  logic       branch_taken = 1'b0;

  logic        s1_sel, s1_pcw, s1_ifw, s1_iff, s1_exf;
  logic [1:0]  s1_state;
  logic [31:0] s1_stall, s1_flush;
  logic        s2_sel, s2_pcw, s2_ifw, s2_iff, s2_exf;
  logic [1:0]  s2_state;
  logic [1:0]  s2_stall, s2_flush;

  always #5 clock = ~clock;

  hazard_control #(.LOAD_USE_DIST(1), .CNT_W(32)) u1 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_usesRt(id_usesRt), .id_memRead(id_memRead),
    .id_regWrite(id_regWrite), .id_dest(id_dest), .branch_taken(branch_taken),
    .selector(s1_sel), .pcWrite(s1_pcw), .ifidWrite(s1_ifw),
    .ifidFlush(s1_iff), .exmemFlush(s1_exf), .state(s1_state),
    .stallCount(s1_stall), .flushCount(s1_flush)
  );

  hazard_control #(.LOAD_USE_DIST(2), .CNT_W(2)) u2 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_usesRt(id_usesRt), .id_memRead(id_memRead),
    .id_regWrite(id_regWrite), .id_dest(id_dest), .branch_taken(branch_taken),
    .selector(s2_sel), .pcWrite(s2_pcw), .ifidWrite(s2_ifw),
    .ifidFlush(s2_iff), .exmemFlush(s2_exf), .state(s2_state),
    .stallCount(s2_stall), .flushCount(s2_flush)
  );

  typedef struct {
    int          dut;
    logic [4:0]  ctl;
    logic [1:0]  st;
    int unsigned sc;
    int unsigned fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Drive one cycle of inputs just after the edge and queue what must be seen.
  task automatic cyc(input int dut, input logic rst, input logic v,
                     input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic mr, input logic rw, input logic [4:0] dst,
                     input logic br, input logic [4:0] ctl, input logic [1:0] st,
                     input int unsigned sc, input int unsigned fc);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; id_valid = v; id_rs = rs; id_rt = rt; id_usesRt = ur;
    id_memRead = mr; id_regWrite = rw; id_dest = dst; branch_taken = br;
    e.dut = dut; e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc;
    sb.push_back(e);
  endtask

  // Monitor: the outputs are valid every cycle, so one entry is consumed per cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [4:0]  a_ctl;
      logic [1:0]  a_st;
      int unsigned a_sc, a_fc;
      e = sb.pop_front();
      if (e.dut == 1) begin
        a_ctl = {s1_sel, s1_pcw, s1_ifw, s1_iff, s1_exf};
        a_st  = s1_state;
        a_sc  = s1_stall;
        a_fc  = s1_flush;
      end else begin
        a_ctl = {s2_sel, s2_pcw, s2_ifw, s2_iff, s2_exf};
        a_st  = s2_state;
        a_sc  = int'(s2_stall);
        a_fc  = int'(s2_flush);
      end
      checks++;
      if (a_ctl !== e.ctl || a_st !== e.st || a_sc != e.sc || a_fc != e.fc) begin
        failures++;
        $display("FAIL txn%0d dut%0d: got ctl=%b state=%0d stall=%0d flush=%0d, want ctl=%b state=%0d stall=%0d flush=%0d",
                 checks, e.dut, a_ctl, a_st, a_sc, a_fc, e.ctl, e.st, e.sc, e.fc);
      end else begin
        $display("txn%0d dut%0d ctl=%b state=%0d stall=%0d flush=%0d ok",
                 checks, e.dut, a_ctl, a_st, a_sc, a_fc);
      end
    end
  end

  initial begin
    // Full forwarding instance.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    cyc(1, 0, 1, 2, 8, 0, 1, 1, 8, 0, C_RUN, 0, 0, 0);     // lw $8
    cyc(1, 0, 1, 8, 9, 1, 0, 1, 10, 0, C_STALL, 0, 0, 0);  // add rs=$8
    cyc(1, 0, 1, 8, 9, 1, 0, 1, 10, 0, C_RUN, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 1, 0);
    cyc(1, 0, 1, 2, 8, 0, 1, 1, 8, 0, C_RUN, 0, 1, 0);     // lw $8
    cyc(1, 0, 1, 3, 8, 0, 0, 1, 11, 0, C_RUN, 0, 1, 0);    // rt=$8, rt unused
    cyc(1, 0, 1, 2, 0, 0, 1, 1, 0, 0, C_RUN, 0, 1, 0);     // lw $0
    cyc(1, 0, 1, 0, 0, 1, 0, 1, 12, 0, C_RUN, 0, 1, 0);    // use $0
    cyc(1, 0, 1, 2, 3, 1, 0, 1, 8, 0, C_RUN, 0, 1, 0);     // alu writes $8
    cyc(1, 0, 1, 8, 0, 0, 0, 1, 13, 0, C_RUN, 0, 1, 0);    // use $8
    cyc(1, 0, 1, 2, 8, 0, 1, 1, 8, 0, C_RUN, 0, 1, 0);     // lw $8
    cyc(1, 0, 1, 8, 9, 1, 0, 1, 10, 1, C_FLUSH, 0, 1, 0);  // hazard + branch
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 1, 1);
    cyc(1, 0, 1, 2, 8, 0, 1, 1, 8, 0, C_RUN, 0, 1, 1);     // lw $8
    cyc(1, 1, 1, 8, 9, 1, 0, 1, 10, 0, C_STALL, 0, 1, 1);  // reset during stall
    cyc(1, 0, 1, 8, 9, 1, 0, 1, 10, 0, C_RUN, 0, 0, 0);

    // MEM-distance instance with 2-bit counters.
    cyc(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    cyc(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    cyc(2, 0, 1, 2, 8, 0, 1, 1, 8, 0, C_RUN, 0, 0, 0);     // lw $8
    cyc(2, 0, 1, 9, 8, 1, 0, 1, 10, 0, C_STALL, 0, 0, 0);  // rt=$8, rt used
    cyc(2, 0, 1, 9, 8, 1, 0, 1, 10, 0, C_STALL, 1, 1, 0);
    cyc(2, 0, 1, 9, 8, 1, 0, 1, 10, 0, C_RUN, 1, 2, 0);
    cyc(2, 0, 1, 2, 8, 0, 1, 1, 8, 0, C_RUN, 0, 2, 0);     // lw $8
    cyc(2, 0, 1, 3, 8, 0, 0, 1, 11, 0, C_RUN, 0, 2, 0);    // rt unused
    cyc(2, 0, 1, 8, 9, 1, 0, 1, 10, 0, C_STALL, 0, 2, 0);  // load now in MEM
    cyc(2, 0, 1, 8, 9, 1, 0, 1, 10, 0, C_RUN, 1, 3, 0);
    cyc(2, 0, 1, 2, 8, 0, 1, 1, 8, 0, C_RUN, 0, 3, 0);     // lw $8
    cyc(2, 0, 1, 8, 9, 1, 0, 1, 10, 0, C_STALL, 0, 3, 0);
    cyc(2, 0, 1, 8, 9, 1, 0, 1, 10, 0, C_STALL, 1, 0, 0);  // counter wrapped
    cyc(2, 0, 1, 8, 9, 1, 0, 1, 10, 0, C_RUN, 1, 1, 0);
    cyc(2, 0, 1, 2, 8, 0, 1, 1, 8, 0, C_RUN, 0, 1, 0);     // lw $8
    cyc(2, 0, 1, 8, 9, 1, 0, 1, 10, 1, C_FLUSH, 0, 1, 0);  // hazard + branch
    cyc(2, 0, 1, 8, 9, 1, 0, 1, 10, 0, C_RUN, 2, 1, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
